// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit among NREQ requesters.
// Accepts one request at a time and returns a tagged, registered result.
module logic_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_op,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [WIDTH-1:0]      resp_data,
  output logic [IDW-1:0]        resp_id,
  output logic                  resp_err,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [IDW-1:0]   last, grant, grant_hi, grant_lo, g_p0;
  logic             found_hi, found_lo, any_req;
  logic [WIDTH-1:0] sel_a, sel_b, a_p0, b_p0;
  logic [2:0]       sel_op, op_p0;
  logic [WIDTH:0]   res_p0;

  // MSB carries the illegal-opcode flag.
  function automatic logic [WIDTH:0] logic_op(input logic [2:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, ~a};
      3'd3:    return {1'b0, ~(a & b)};
      3'd4:    return {1'b0, ~(a | b)};
      3'd5:    return {1'b0, a ^ b};
      3'd6:    return {1'b0, ~(a ^ b)};
      default: return {1'b1, {WIDTH{1'b0}}};
    endcase
  endfunction

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Round-robin pick: first requester above last wins, else lowest index.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    grant_hi = '0;
    grant_lo = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && !found_lo) begin
        found_lo = 1'b1;
        grant_lo = IDW'(i);
      end
      if (req_valid[i] && (i > int'(last)) && !found_hi) begin
        found_hi = 1'b1;
        grant_hi = IDW'(i);
      end
    end
    grant   = found_hi ? grant_hi : grant_lo;
    any_req = |req_valid;
  end

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == grant) begin
        sel_a  = req_a[i*WIDTH +: WIDTH];
        sel_b  = req_b[i*WIDTH +: WIDTH];
        sel_op = req_op[i*3 +: 3];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (any_req) begin
          for (int i = 0; i < NREQ; i++) req_ready[i] = (IDW'(i) == grant);
          state_nxt = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy   = (state != IDLE);
  assign res_p0 = logic_op(op_p0, a_p0, b_p0);

  // p0: operand capture at acceptance; held until the next grant
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      a_p0  <= sel_a;
      b_p0  <= sel_b;
      op_p0 <= sel_op;
    end
  end

  // p1: result/response registers and arbitration control
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IDW'(NREQ - 1);
      g_p0       <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_err   <= 1'b0;
      op_count   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (any_req) g_p0 <= grant;
        EXEC: begin
          resp_data  <= res_p0[WIDTH-1:0];
          resp_err   <= res_p0[WIDTH];
          resp_id    <= g_p0;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            last       <= g_p0;
            op_count   <= sat_inc(op_count);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter (4 requesters, 8-bit, 4-bit counter).
module tb_logic_op_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_a = '0, req_b = '0;
  logic [11:0] req_op = '0;
  logic [3:0]  req_ready;
  logic        resp_valid, resp_ready = 1'b0, resp_err, busy;
  logic [7:0]  resp_data;
  logic [1:0]  resp_id;
  logic [3:0]  op_count;

  logic_op_arbiter #(.WIDTH(8), .NREQ(4), .IDW(2), .CNTW(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_op(req_op), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_data(resp_data), .resp_id(resp_id),
    .resp_err(resp_err), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [8:0] ref_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0: ref_op = {1'b0, a & b};
      3'd1: ref_op = {1'b0, a | b};
      3'd2: ref_op = {1'b0, ~a};
      3'd3: ref_op = {1'b0, ~(a & b)};
      3'd4: ref_op = {1'b0, ~(a | b)};
      3'd5: ref_op = {1'b0, a ^ b};
      3'd6: ref_op = {1'b0, ~(a ^ b)};
      default: ref_op = 9'h100;
    endcase
  endfunction

  function automatic int pick(input logic [3:0] v, input logic [1:0] lst);
    for (int k = 1; k <= 4; k++) begin
      int idx = (int'(lst) + k) % 4;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  typedef struct { logic [7:0] d; logic [1:0] id; logic e; int acc; } exp_t;
  exp_t sb[$];
  int   grant_log[$], grant_cyc[$];
  logic [1:0] m_last = 2'd3;
  bit   m_busy = 0, cnt_chk = 0, seen = 0;
  int   m_cnt = 0;

  // Reference model: arbitration, busy tracking, expected results
  always @(negedge clk) begin
    int g;
    logic [8:0] r;
    if (rst) begin
      sb.delete(); m_last = 2'd3; m_busy = 0; m_cnt = 0; cnt_chk = 0; seen = 0;
    end else begin
      if (cnt_chk) begin check("op_count", op_count, m_cnt); cnt_chk = 0; end
      check("busy", busy, m_busy);
      if (!m_busy) begin
        check("idle_resp_valid", resp_valid, 0);
        g = pick(req_valid, m_last);
        check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        if (g >= 0) begin
          r = ref_op(req_op[g*3 +: 3], req_a[g*8 +: 8], req_b[g*8 +: 8]);
          sb.push_back('{d: r[7:0], id: g[1:0], e: r[8], acc: cyc});
          grant_log.push_back(g);
          grant_cyc.push_back(cyc);
          m_busy = 1;
        end
      end else begin
        check("busy_req_ready", req_ready, 0);
        if (resp_valid) begin
          if (sb.size() == 0) check("resp_spurious", 1, 0);
          else begin
            if (!seen) begin check("latency", cyc - sb[0].acc, 2); seen = 1; end
            check("resp_data", resp_data, sb[0].d);
            check("resp_id", resp_id, sb[0].id);
            check("resp_err", resp_err, sb[0].e);
            if (resp_ready) begin
              m_last = sb[0].id;
              void'(sb.pop_front());
              m_busy = 0; seen = 0; cnt_chk = 1;
              if (m_cnt < 15) m_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic send(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bit ok = 0;
    @(posedge clk); #1;
    req_a[i*8 +: 8] = a; req_b[i*8 +: 8] = b; req_op[i*3 +: 3] = op; req_valid[i] = 1'b1;
    for (int k = 0; k < 30 && !ok; k++) begin
      @(negedge clk);
      if (req_valid[i] && req_ready[i]) ok = 1;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    req_a[i*8 +: 8] = 8'($urandom);
    req_op[i*3 +: 3] = 3'($urandom);
  endtask

  task automatic wait_resp(output logic [7:0] d, output logic [1:0] id, output logic e);
    bit ok = 0;
    d = '0; id = '0; e = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin ok = 1; d = resp_data; id = resp_id; e = resp_err; end
    end
    if (!ok) check("resp_timeout", 0, 1);
  endtask

  task automatic apply_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic wait_grants(input int n);
    for (int k = 0; k < 80 && grant_log.size() < n; k++) @(negedge clk);
    if (grant_log.size() < n) check("grant_timeout", grant_log.size(), n);
  endtask

  initial begin
    logic [7:0] d, hd; logic [1:0] id, hid; logic e;
    logic [7:0] tbl [8];
    bit ok;
    tbl = '{8'hC0, 8'hFC, 8'h0F, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h00};

    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single XOR on requester 0
    resp_ready = 1'b1;
    send(0, 8'hC3, 8'h5A, 3'd5);
    wait_resp(d, id, e);
    check("t1_data", d, 8'h99);
    check("t1_id", id, 0);
    check("t1_err", e, 0);
    @(posedge clk); #1;
    check("t1_op_count", op_count, 1);

    // Every opcode on requester 2
    for (int op = 0; op < 8; op++) begin
      send(2, 8'hF0, 8'hCC, 3'(op));
      wait_resp(d, id, e);
      check("t2_data", d, tbl[op]);
      check("t2_err", e, (op == 7));
      check("t2_id", id, 2);
    end

    // All requesters continuously active
    apply_reset();
    grant_log.delete(); grant_cyc.delete();
    @(posedge clk); #1;
    req_a = 32'h8844_2211; req_b = 32'hF00F_55AA; req_op = 12'b110_101_011_001;
    req_valid = 4'hF;
    wait_grants(6);
    @(posedge clk); #1 req_valid = '0;
    repeat (8) @(posedge clk);
    for (int k = 0; k < 6 && k < grant_log.size(); k++) begin
      check("t3_order", grant_log[k], k % 4);
      if (k > 0) check("t3_gap", grant_cyc[k] - grant_cyc[k-1], 3);
    end

    // Back-pressure in RESP while another requester waits
    resp_ready = 1'b0;
    send(1, 8'h3C, 8'h0F, 3'd1);
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin @(negedge clk); ok = resp_valid; end
    if (!ok) check("t4_resp_timeout", 0, 1);
    hd = resp_data; hid = resp_id;
    @(posedge clk); #1 req_valid[3] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("t4_valid_hold", resp_valid, 1);
      check("t4_data_hold", resp_data, hd);
      check("t4_id_hold", resp_id, hid);
      check("t4_req_ready", req_ready, 0);
      check("t4_busy", busy, 1);
    end
    @(posedge clk); #1 resp_ready = 1'b1;
    ok = 0;
    for (int k = 0; k < 10 && !ok; k++) begin @(negedge clk); ok = req_ready[3]; end
    if (!ok) check("t4_grant3_timeout", 0, 1);
    @(posedge clk); #1 req_valid[3] = 1'b0;
    wait_resp(d, id, e);
    check("t4_id3", id, 3);

    // Reset while an operation is in EXEC
    send(0, 8'hAA, 8'h55, 3'd1);
    rst = 1'b1;
    #1;
    check("t5_resp_valid", resp_valid, 0);
    check("t5_op_count", op_count, 0);
    check("t5_busy", busy, 0);
    grant_log.delete(); grant_cyc.delete();
    req_valid = 4'b1010;
    @(posedge clk); #1;
    check("t5_resp_valid_hold", resp_valid, 0);
    @(posedge clk); #1 rst = 1'b0;
    wait_grants(1);
    @(posedge clk); #1 req_valid = 4'b1000;
    wait_grants(2);
    @(posedge clk); #1 req_valid = '0;
    if (grant_log.size() >= 2) begin
      check("t5_first", grant_log[0], 1);
      check("t5_second", grant_log[1], 3);
    end
    repeat (8) @(posedge clk);

    // Random traffic with withdrawal and random back-pressure
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      req_valid  = 4'($urandom);
      req_a      = $urandom; req_b = $urandom;
      req_op     = 12'($urandom);
      resp_ready = 1'($urandom);
    end
    @(posedge clk); #1 req_valid = '0; resp_ready = 1'b1;
    repeat (10) @(posedge clk);
    check("sb_empty", sb.size(), 0);

    // Counter saturation
    apply_reset();
    for (int t = 0; t < 18; t++) begin
      send(t % 4, 8'(t), 8'hA5, 3'(t % 7));
      wait_resp(d, id, e);
    end
    @(posedge clk); #1;
    check("t6_saturated", op_count, 4'hF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
